// File: rtl/ctrl_seq_pkg.sv
// Shared encodings for the accumulator CPU sequencer:
// opcodes, FSM states, ALU op codes and halt error codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPND,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_JZ) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Memory bus between sequencer (master) and memory (slave).
// req/we/addr held by master until ack; rdata valid with ack.
interface ctrl_seq_if #(
  parameter int DW = 8,
  parameter int AW = 8
) ();
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ctrl_seq_ack_timer.sv
// Counts request cycles without ack; expired when LIMIT reached.
// Ports: clk, reset (async low), clr, en, expired.
module ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(LIMIT));

  // saturates at LIMIT so expired stays up until cleared
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer: drives pc, memory bus, acc/alu.
// Ports: clk, reset, mem (bus master), pc_*, acc_*, alu_*, halted, err.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  ctrl_seq_if.master    mem,
  input  logic [AW-1:0] pc_q,
  output logic          pc_load,
  output logic          pc_inc,
  output logic [AW-1:0] pc_din,
  input  logic          acc_zero,
  output logic          acc_load,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_b,
  output logic          halted,
  output logic [1:0]    err
);
  state_e        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] opnd_q, opnd_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          halted_q, halted_d;
  logic [1:0]    err_q, err_d;

  logic          req, we, ack, tmo;
  logic [AW-1:0] addr;
  logic [3:0]    op;

  assign ack          = mem.mem_ack;
  assign op           = ir_q[DW-1 -: 4];
  assign mem.mem_req  = req;
  assign mem.mem_we   = we;
  assign mem.mem_addr = addr;
  assign halted       = halted_q;
  assign err          = err_q;

  // every req state is entered from a non-req cycle or an ack cycle,
  // so clearing on those points restarts the count per access
  ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!req || ack),
    .en      (req && !ack),
    .expired (tmo)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    opnd_d   = opnd_q;
    mdr_d    = mdr_q;
    halted_d = halted_q;
    err_d    = err_q;
    req      = 1'b0;
    we       = 1'b0;
    addr     = '0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_din   = '0;
    acc_load = 1'b0;
    alu_op   = ALU_PASS;
    alu_b    = '0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        req  = 1'b1;
        addr = pc_q;
        if (ack) begin
          ir_d    = mem.mem_rdata;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          op == OP_NOP: state_d = S_FETCH;
          op == OP_HLT: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end
          !op_legal(op): begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            err_d    = ERR_ILL;
          end
          default: state_d = S_OPND;
        endcase
      end
      S_OPND: begin
        req  = 1'b1;
        addr = pc_q;
        if (ack) begin
          opnd_d  = mem.mem_rdata;
          pc_inc  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_din  = AW'(opnd_q);
        unique case (1'b1)
          op == OP_LDI: begin
            acc_load = 1'b1;
            alu_b    = opnd_q;
          end
          op == OP_JMP: pc_load = 1'b1;
          op == OP_JZ:  pc_load = acc_zero;
          default:      state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        req  = 1'b1;
        we   = (op == OP_STA);
        addr = AW'(opnd_q);
        if (ack) begin
          if (op == OP_STA) begin
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        acc_load = 1'b1;
        alu_b    = mdr_q;
        state_d  = S_FETCH;
        unique case (1'b1)
          op == OP_ADD: alu_op = ALU_ADD;
          op == OP_SUB: alu_op = ALU_SUB;
          default:      alu_op = ALU_PASS;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    // bus error wins over a late ack in the same cycle
    if (req && tmo) begin
      state_d  = S_HALT;
      halted_d = 1'b1;
      err_d    = ERR_TMO;
      pc_inc   = 1'b0;
      ir_d     = ir_q;
      opnd_d   = opnd_q;
      mdr_d    = mdr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      opnd_q   <= '0;
      mdr_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      opnd_q   <= opnd_d;
      mdr_q    <= mdr_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end
endmodule
